inst_fetch_bridge: RTL and testbench

Instruction-side bus bridge that services the fetch stage's instruction requests and returns fetched words. Sits between the IF stage (`inst_sram_en`/`pc_next` out, `inst_ready`/`inst_valid`/`inst` in) and a split-handshake instruction memory port (`addr_ok`/`data_ok`). It allows at most one outstanding fetch and buffers the returned word until ID accepts it. On a pipeline flush it discards any in-flight response.

---
 rtl/cpu_defs_pkg.sv | 17 +
 rtl/inst_resp_buf.sv | 34 +++
 rtl/inst_fetch_bridge.sv | 107 ++++++++++
 tb/tb_inst_fetch_bridge.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: fetch FSM encoding, reset PC, bus width defaults.
// No logic; types and constants only.
package cpu_defs_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic [31:0] PC_INIT = 32'h1bfffffc;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/inst_resp_buf.sv
// One-entry fetched-word register with load/clear; load wins over clear.
// Latency: 1 cycle from load to o_vld. Backpressure: holds until cleared.
// Synchronous active-low reset clears both data and valid.
module inst_resp_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_clr,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat,
  output logic         o_vld
);

  logic [W-1:0] r_dat;
  logic         r_vld;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dat <= '0;
      r_vld <= 1'b0;
    end else if (i_load) begin
      r_dat <= i_dat;
      r_vld <= 1'b1;
    end else if (i_clr) begin
      r_vld <= 1'b0;
    end
  end

  assign o_dat = r_dat;
  assign o_vld = r_vld;

endmodule

// File: rtl/inst_fetch_bridge.sv
// IF-side bridge to a split addr_ok/data_ok instruction port, one fetch in flight.
// Latency: accept in cycle 0, mem_req in cycle 1, inst_valid in cycle 3 (zero-wait bus).
// Backpressure: word held until ID_allowin; new requests refused while holding or cancelling.
module inst_fetch_bridge
  import cpu_defs_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_sram_en,
  input  logic [ADDR_W-1:0] pc_next,
  input  logic              ID_allowin,
  input  logic              flush,
  output logic              inst_ready,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic              r_cancel;
  logic              w_cancel_nxt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              w_accept;
  logic              w_load;
  logic              w_clr;

  // A cancelled fetch must drain from the bus before anything new is issued.
  assign w_accept = rst & inst_sram_en & ~r_cancel &
                    ((r_state == S_IDLE) |
                     ((r_state == S_HOLD) & ID_allowin & ~flush));

  always_comb begin
    w_state_nxt  = r_state;
    w_cancel_nxt = r_cancel;
    w_load       = 1'b0;
    w_clr        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_ADDR;
      end
      S_ADDR: begin
        if (flush)       w_cancel_nxt = 1'b1;
        if (mem_addr_ok) w_state_nxt  = S_DATA;
      end
      S_DATA: begin
        if (mem_data_ok) begin
          if (r_cancel | flush) begin
            w_cancel_nxt = 1'b0;
            w_state_nxt  = S_IDLE;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end else if (flush) begin
          w_cancel_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (flush) begin
          w_clr       = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (ID_allowin) begin
          w_clr       = 1'b1;
          w_state_nxt = w_accept ? S_ADDR : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cancel   <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cancel <= w_cancel_nxt;
      if (w_accept) r_mem_addr <= pc_next;
    end
  end

  inst_resp_buf #(
    .W(DATA_W)
  ) u_resp_buf (
    .clk   (clk),
    .rst   (rst),
    .i_load(w_load),
    .i_clr (w_clr),
    .i_dat (mem_rdata),
    .o_dat (inst),
    .o_vld (inst_valid)
  );

  assign inst_ready = w_accept;
  assign mem_req    = (r_state == S_ADDR);
  assign mem_addr   = r_mem_addr;

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Bench for inst_fetch_bridge: directed cycle-by-cycle stimulus, scoreboard of fetched words.
module tb_inst_fetch_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_sram_en;
  logic [31:0] pc_next;
  logic        ID_allowin;
  logic        flush;
  logic        inst_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic        r_prev_vld = 1'b0;

  always #5 clk = ~clk;

  inst_fetch_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_sram_en(inst_sram_en),
    .pc_next     (pc_next),
    .ID_allowin  (ID_allowin),
    .flush       (flush),
    .inst_ready  (inst_ready),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok),
    .mem_rdata   (mem_rdata)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1e800c0c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance to the next cycle and return all inputs to their idle values.
  task automatic cyc();
    @(posedge clk);
    #1;
    inst_sram_en = 1'b0;
    ID_allowin   = 1'b0;
    flush        = 1'b0;
    mem_addr_ok  = 1'b0;
    mem_data_ok  = 1'b0;
    mem_rdata    = '0;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard: each rising inst_valid consumes one expected word.
  always @(posedge clk) begin
    #3;
    if (rst && inst_valid && !r_prev_vld) begin
      if (exp_q.size() == 0) chk("sb_unexpected_valid", {31'd0, inst_valid}, 32'd0);
      else chk("sb_word", inst, exp_q.pop_front());
    end
    r_prev_vld = inst_valid & rst;
  end

  initial begin
    logic [31:0] held;
    rst          = 1'b0;
    inst_sram_en = 1'b0;
    pc_next      = '0;
    ID_allowin   = 1'b0;
    flush        = 1'b0;
    mem_addr_ok  = 1'b0;
    mem_data_ok  = 1'b0;
    mem_rdata    = '0;

    // Reset, with a request presented that must not be taken.
    cyc(); inst_sram_en = 1'b1; pc_next = 32'h1c000000;
    cyc(); inst_sram_en = 1'b1; pc_next = 32'h1c000000;
    smp();
    chk("rst_inst_ready", {31'd0, inst_ready}, 32'd0);
    chk("rst_mem_req",    {31'd0, mem_req},    32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst",       inst,                32'd0);
    chk("rst_mem_addr",   mem_addr,            32'd0);

    // Zero-wait fetch.
    cyc(); rst = 1'b1; inst_sram_en = 1'b1; pc_next = 32'h1c000000;
    smp(); chk("c0_inst_ready", {31'd0, inst_ready}, 32'd1);
    exp_q.push_back(mem_word(32'h1c000000));
    cyc(); mem_addr_ok = 1'b1;
    smp(); chk("c1_mem_req", {31'd0, mem_req}, 32'd1);
    chk("c1_mem_addr", mem_addr, 32'h1c000000);
    cyc(); mem_data_ok = 1'b1; mem_rdata = mem_word(mem_addr);
    smp(); chk("c2_mem_req", {31'd0, mem_req}, 32'd0);
    chk("c2_inst_valid", {31'd0, inst_valid}, 32'd0);

    // HOLD with no consumer for 4 cycles.
    for (int i = 0; i < 4; i++) begin
      cyc(); inst_sram_en = 1'b1; pc_next = 32'h1c000004;
      smp();
      if (i == 0) begin
        chk("c3_inst", inst, 32'h02800c0c);
        held = 32'h02800c0c;
      end
      chk("hold_valid", {31'd0, inst_valid}, 32'd1);
      chk("hold_inst",  inst, held);
      chk("hold_ready", {31'd0, inst_ready}, 32'd0);
    end
    cyc(); inst_sram_en = 1'b1; pc_next = 32'h1c000004; ID_allowin = 1'b1;
    smp(); chk("b2b_ready", {31'd0, inst_ready}, 32'd1);
    exp_q.push_back(mem_word(32'h1c000004));

    // addr_ok delayed 3 cycles.
    for (int i = 0; i < 4; i++) begin
      cyc(); mem_addr_ok = (i == 3); pc_next = 32'h1c0000f0;
      smp();
      chk("slow_mem_req",  {31'd0, mem_req}, 32'd1);
      chk("slow_mem_addr", mem_addr, 32'h1c000004);
      if (i == 0) chk("b2b_valid_clr", {31'd0, inst_valid}, 32'd0);
    end
    cyc(); mem_data_ok = 1'b1; mem_rdata = mem_word(mem_addr);
    smp(); chk("slow_data_req", {31'd0, mem_req}, 32'd0);
    cyc(); ID_allowin = 1'b1;
    smp(); chk("slow_valid", {31'd0, inst_valid}, 32'd1);
    cyc();
    smp(); chk("consumed_valid", {31'd0, inst_valid}, 32'd0);

    // Flush in DATA; response dropped.
    cyc(); inst_sram_en = 1'b1; pc_next = 32'h1c000080;
    smp(); chk("fl_accept", {31'd0, inst_ready}, 32'd1);
    cyc(); mem_addr_ok = 1'b1;
    cyc(); flush = 1'b1;
    smp(); chk("fl_data_req", {31'd0, mem_req}, 32'd0);
    cyc(); inst_sram_en = 1'b1; pc_next = 32'h1c000100;
    smp(); chk("fl_cancel_ready", {31'd0, inst_ready}, 32'd0);
    chk("fl_valid_a", {31'd0, inst_valid}, 32'd0);
    cyc(); inst_sram_en = 1'b1; pc_next = 32'h1c000100;
    mem_data_ok = 1'b1; mem_rdata = 32'hdeadbeef;
    smp(); chk("fl_drop_ready", {31'd0, inst_ready}, 32'd0);
    chk("fl_valid_b", {31'd0, inst_valid}, 32'd0);
    cyc(); inst_sram_en = 1'b1; pc_next = 32'h1c000100;
    smp(); chk("fl_after_ready", {31'd0, inst_ready}, 32'd1);
    chk("fl_valid_c", {31'd0, inst_valid}, 32'd0);
    exp_q.push_back(mem_word(32'h1c000100));
    cyc(); mem_addr_ok = 1'b1;
    smp(); chk("fl_next_addr", mem_addr, 32'h1c000100);
    cyc(); mem_data_ok = 1'b1; mem_rdata = mem_word(mem_addr);

    // Flush in HOLD.
    cyc(); flush = 1'b1; ID_allowin = 1'b1; inst_sram_en = 1'b1; pc_next = 32'h1c000104;
    smp(); chk("hf_valid", {31'd0, inst_valid}, 32'd1);
    chk("hf_ready", {31'd0, inst_ready}, 32'd0);
    cyc();
    smp(); chk("hf_valid_clr", {31'd0, inst_valid}, 32'd0);
    chk("hf_req", {31'd0, mem_req}, 32'd0);

    // Flush in IDLE with a request.
    cyc(); flush = 1'b1; inst_sram_en = 1'b1; pc_next = 32'h1c000200;
    smp(); chk("if_ready", {31'd0, inst_ready}, 32'd1);
    exp_q.push_back(mem_word(32'h1c000200));
    cyc(); mem_addr_ok = 1'b1;
    smp(); chk("if_req", {31'd0, mem_req}, 32'd1);
    chk("if_addr", mem_addr, 32'h1c000200);
    cyc(); mem_data_ok = 1'b1; mem_rdata = mem_word(mem_addr);
    cyc(); ID_allowin = 1'b1;
    cyc();

    // Reset while in ADDR.
    cyc(); inst_sram_en = 1'b1; pc_next = 32'h1c000300;
    smp(); chk("ra_accept", {31'd0, inst_ready}, 32'd1);
    cyc(); rst = 1'b0;
    smp(); chk("ra_req_before", {31'd0, mem_req}, 32'd1);
    cyc();
    smp(); chk("ra_req",   {31'd0, mem_req},    32'd0);
    chk("ra_valid",        {31'd0, inst_valid}, 32'd0);
    chk("ra_addr",         mem_addr,            32'd0);
    chk("ra_ready",        {31'd0, inst_ready}, 32'd0);
    cyc(); rst = 1'b1; inst_sram_en = 1'b1; pc_next = 32'h1c000400;
    smp(); chk("ra_idle_accept", {31'd0, inst_ready}, 32'd1);
    exp_q.push_back(mem_word(32'h1c000400));
    cyc(); mem_addr_ok = 1'b1;
    cyc(); mem_data_ok = 1'b1; mem_rdata = mem_word(mem_addr);
    cyc(); ID_allowin = 1'b1;
    cyc();
    cyc();

    chk("sb_pending", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
